// File: rtl/mux_rr_arbiter.sv
// mux_rr_arbiter: round-robin arbiter and sequencer for a shared 2:1 mux.
// Two requesters compete for one output channel. A grant lasts for one
// bounded burst. The granted requester's word is forwarded under a
// valid/ready handshake, and this block is the only driver of the mux select.
module mux_rr_arbiter #(
   parameter int WIDTH     = 8,
   parameter int MAX_BURST = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             req_a,
   input  logic [WIDTH-1:0] data_a,
   input  logic             last_a,
   output logic             ready_a,
   input  logic             req_b,
   input  logic [WIDTH-1:0] data_b,
   input  logic             last_b,
   output logic             ready_b,
   output logic             sel,
   output logic             gnt_a,
   output logic             gnt_b,
   output logic             out_valid,
   output logic [WIDTH-1:0] out_data,
   input  logic             out_ready,
   output logic             busy
);

   localparam int CW = $clog2(MAX_BURST) + 1;

   localparam logic [1:0] ST_IDLE  = 2'b00;
   localparam logic [1:0] ST_GNT_A = 2'b01;
   localparam logic [1:0] ST_GNT_B = 2'b10;

   // Count value of the final transfer allowed in one burst
   localparam logic [CW-1:0] CNT_LAST = CW'(MAX_BURST - 1);

   logic [1:0]    state_q, state_d;
   logic          sel_q, sel_d;
   logic          gnt_a_q, gnt_a_d;
   logic          gnt_b_q, gnt_b_d;
   logic          busy_q, busy_d;
   logic          prio_q, prio_d;
   logic [CW-1:0] cnt_q, cnt_d;

   logic          out_valid_s;
   logic          xfer_s;
   logic          rel_s;

   // Handshake decode from the registered grants; data follows the registered select
   always_comb begin
      out_valid_s = (gnt_a_q & req_a) | (gnt_b_q & req_b);
      xfer_s      = out_valid_s & out_ready;
   end

   assign out_valid = out_valid_s;
   assign out_data  = sel_q ? data_b : data_a;
   assign ready_a   = gnt_a_q & req_a & out_ready;
   assign ready_b   = gnt_b_q & req_b & out_ready;
   assign sel       = sel_q;
   assign gnt_a     = gnt_a_q;
   assign gnt_b     = gnt_b_q;
   assign busy      = busy_q;

   // Next-state logic: grant selection, burst counting and release/handover
   always_comb begin
      state_d = state_q;
      sel_d   = sel_q;
      prio_d  = prio_q;
      cnt_d   = cnt_q;
      rel_s   = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (req_a && req_b) begin
               if (prio_q) begin
                  state_d = ST_GNT_B;
                  sel_d   = 1'b1;
                  cnt_d   = '0;
               end else begin
                  state_d = ST_GNT_A;
                  sel_d   = 1'b0;
                  cnt_d   = '0;
               end
            end else if (req_a) begin
               state_d = ST_GNT_A;
               sel_d   = 1'b0;
               cnt_d   = '0;
            end else if (req_b) begin
               state_d = ST_GNT_B;
               sel_d   = 1'b1;
               cnt_d   = '0;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_GNT_A: begin
            // A single release even when last and the burst limit coincide
            rel_s = (xfer_s && (last_a || (cnt_q == CNT_LAST))) || !req_a;
            if (rel_s) begin
               prio_d = 1'b1;
               cnt_d  = '0;
               if (req_b) begin
                  state_d = ST_GNT_B;
                  sel_d   = 1'b1;
               end else if (req_a) begin
                  state_d = ST_GNT_A;
                  sel_d   = 1'b0;
               end else begin
                  state_d = ST_IDLE;
               end
            end else if (xfer_s) begin
               cnt_d = cnt_q + CW'(1);
            end else begin
               cnt_d = cnt_q;
            end
         end
         ST_GNT_B: begin
            rel_s = (xfer_s && (last_b || (cnt_q == CNT_LAST))) || !req_b;
            if (rel_s) begin
               prio_d = 1'b0;
               cnt_d  = '0;
               if (req_a) begin
                  state_d = ST_GNT_A;
                  sel_d   = 1'b0;
               end else if (req_b) begin
                  state_d = ST_GNT_B;
                  sel_d   = 1'b1;
               end else begin
                  state_d = ST_IDLE;
               end
            end else if (xfer_s) begin
               cnt_d = cnt_q + CW'(1);
            end else begin
               cnt_d = cnt_q;
            end
         end
         default: begin
            state_d = ST_IDLE;
            sel_d   = 1'b0;
            cnt_d   = '0;
         end
      endcase
   end

   // Registered status outputs decoded from the next state
   always_comb begin
      gnt_a_d = (state_d == ST_GNT_A);
      gnt_b_d = (state_d == ST_GNT_B);
      busy_d  = (state_d != ST_IDLE);
   end

   // State, select, priority and burst counter registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         sel_q   <= 1'b0;
         gnt_a_q <= 1'b0;
         gnt_b_q <= 1'b0;
         busy_q  <= 1'b0;
         prio_q  <= 1'b0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         sel_q   <= sel_d;
         gnt_a_q <= gnt_a_d;
         gnt_b_q <= gnt_b_d;
         busy_q  <= busy_d;
         prio_q  <= prio_d;
         cnt_q   <= cnt_d;
      end
   end

endmodule
